if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the fetch PC, reads each 32-bit instruction as four little-endian bytes over the shared byte-wide memory port, and presents `flag_o`/`pc_o`/`inst_o` to the if_id register, which feeds the decoder. Accepts redirects from ex and back-pressure from the stall controller. An optional direct-mapped instruction cache is available.

---
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch, byte-serial memory port, optional direct-mapped icache (macro ICACHE_EN)
//   clk, rst (sync, active-high), rdy (global enable), stall_i (downstream busy)
//   jump_i/jump_addr_i (redirect from ex), mem_grant_i/mem_data_i (memory port response)
//   mem_req_o/mem_addr_o (byte read request), flag_o/pc_o/inst_o (to if_id)
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_IDX_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        flag_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t state, state_nx;
    logic [31:0] pc, word_q, word_nx, hit_word;
    logic [2:0] issue_cnt, recv_cnt, recv_nx;
    logic got, drop_pending, cap, grant, hit, done, fill;
    // got marks a byte returning this cycle; a redirect in the previous cycle voids it
    assign grant = mem_req_o && mem_grant_i;
    assign cap = got && !drop_pending;
    assign recv_nx = recv_cnt + {2'b0, cap};
    assign done = state == FETCH && recv_nx == 3'd4;
    assign fill = rdy && !jump_i && done;
    always_comb begin
        word_nx = word_q;
        if (cap) word_nx[{recv_cnt[1:0], 3'b000} +: 8] = mem_data_i;
    end
`ifdef ICACHE_EN
    localparam int N  = 1 << ICACHE_IDX_W;
    localparam int TW = 30 - ICACHE_IDX_W;
    logic [N-1:0] c_valid;
    logic [TW-1:0] c_tag [N];
    logic [31:0] c_data [N];
    logic [ICACHE_IDX_W-1:0] idx;
    assign idx = pc[ICACHE_IDX_W+1:2];
    // misaligned PCs never hit; a fill to the looked-up index in the same cycle reads as a miss
    assign hit = state == IDLE && pc[1:0] == 2'b00 && c_valid[idx]
                 && c_tag[idx] == pc[31:ICACHE_IDX_W+2] && !fill;
    assign hit_word = c_data[idx];
    always_ff @(posedge clk) begin
        if (rst) c_valid <= '0;
        else if (fill && pc[1:0] == 2'b00) c_valid[idx] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (fill && pc[1:0] == 2'b00) begin
            c_tag[idx] <= pc[31:ICACHE_IDX_W+2];
            c_data[idx] <= word_nx;
        end
    end
`else
    // no cache: never hits
    assign hit = ICACHE_IDX_W < 0;
    assign hit_word = '0;
`endif
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        mem_req_o = 1'b0;
        mem_addr_o = '0;
        if (!rst && rdy) begin
            // IDLE issues byte 0 itself so a fetch starts the cycle after acceptance/redirect
            mem_req_o = (state == IDLE && !hit) || (state == FETCH && issue_cnt != 3'd4);
            mem_addr_o = mem_req_o ? pc + {29'b0, issue_cnt} : '0;
            state_nx = jump_i ? IDLE :
                       state == IDLE ? (hit ? HOLD : FETCH) :
                       state == FETCH ? (done ? HOLD : FETCH) :
                       (stall_i ? HOLD : IDLE);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            issue_cnt <= '0;
            recv_cnt <= '0;
            word_q <= '0;
            got <= 1'b0;
            drop_pending <= 1'b0;
            flag_o <= 1'b0;
            pc_o <= '0;
            inst_o <= '0;
        end else begin
            // byte capture ignores rdy: a byte granted before a freeze still lands
            got <= grant;
            drop_pending <= rdy && jump_i;
            if (cap) begin
                word_q <= word_nx;
                recv_cnt <= recv_nx;
            end
            if (rdy) begin
                if (grant) issue_cnt <= issue_cnt + 3'd1;
                if (jump_i) begin
                    pc <= jump_addr_i;
                    flag_o <= 1'b0;
                    issue_cnt <= '0;
                    recv_cnt <= '0;
                end else if (state == IDLE && hit) begin
                    flag_o <= 1'b1;
                    pc_o <= pc;
                    inst_o <= hit_word;
                end else if (done) begin
                    flag_o <= 1'b1;
                    pc_o <= pc;
                    inst_o <= word_nx;
                    issue_cnt <= '0;
                    recv_cnt <= '0;
                end else if (state == HOLD && !stall_i) begin
                    pc <= pc + 32'd4;
                    flag_o <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage against a byte-memory reference model
module tb_if_stage;
    logic clk = 1'b0;
    logic rst, rdy, stall_i, jump_i, mem_grant_i;
    logic [31:0] jump_addr_i;
    logic [7:0] mem_data_i;
    logic mem_req_o, flag_o;
    logic [31:0] mem_addr_o, pc_o, inst_o;
    int total = 0;
    int bad = 0;
    logic [7:0] mem [512];
    logic [31:0] exp_pc;
    int exp_k;
    logic pend, jumped, prev_flag;
    logic [31:0] pend_addr, prev_pc, prev_inst;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i), .jump_i(jump_i),
        .jump_addr_i(jump_addr_i), .mem_grant_i(mem_grant_i), .mem_data_i(mem_data_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .flag_o(flag_o),
        .pc_o(pc_o), .inst_o(inst_o)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [8:0] b;
        b = a[8:0];
        return {mem[b + 9'd3], mem[b + 9'd2], mem[b + 9'd1], mem[b]};
    endfunction

    // called at a negedge: advance the reference model with this cycle's observations, then clock
    task automatic tick();
        pend = rdy && mem_req_o && mem_grant_i;
        pend_addr = mem_addr_o;
        jumped = !rst && rdy && jump_i;
        prev_flag = flag_o;
        prev_pc = pc_o;
        prev_inst = inst_o;
        if (rst) begin
            exp_pc = 32'h0;
            exp_k = 0;
        end else if (rdy) begin
            if (jump_i) begin
                exp_pc = jump_addr_i;
                exp_k = 0;
            end else if (flag_o && !stall_i) begin
                exp_pc = exp_pc + 32'd4;
                exp_k = 0;
            end else if (mem_req_o && mem_grant_i) exp_k++;
        end
        @(posedge clk);
        #1;
        mem_data_i = pend ? mem[pend_addr[8:0]] : 8'($urandom);
    endtask

    task automatic test_reset();
        logic [31:0] ea;
        rst = 1; rdy = 1; stall_i = 0; jump_i = 0; jump_addr_i = 0; mem_grant_i = 1; mem_data_i = 0;
        @(negedge clk); tick();
        @(negedge clk);
        total++; if (flag_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
            bad++; $display("FAIL reset_out flag=%b pc=%h inst=%h expected 0 0 0", flag_o, pc_o, inst_o);
        end
        total++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            bad++; $display("FAIL reset_mem req=%b addr=%h expected 0 0", mem_req_o, mem_addr_o);
        end
        tick();
        rst = 0;
        for (int c = 1; c <= 6; c++) begin
            stall_i = (c == 6);
            @(negedge clk);
            ea = (c <= 4) ? 32'(c - 1) : 32'h0;
            total++; if (mem_req_o !== (c <= 4) || mem_addr_o !== ea) begin
                bad++; $display("FAIL first_fetch c=%0d req=%b addr=%h expected %b %h", c, mem_req_o, mem_addr_o, c <= 4, ea);
            end
            total++; if (flag_o !== (c == 6)) begin
                bad++; $display("FAIL first_flag c=%0d flag=%b expected %b", c, flag_o, c == 6);
            end
            if (c < 6) tick();
        end
        total++; if (pc_o !== 32'h0 || inst_o !== 32'h00500513) begin
            bad++; $display("FAIL first_word pc=%h inst=%h expected 0 00500513", pc_o, inst_o);
        end
        tick();
    endtask

    task automatic test_stall();
        for (int c = 0; c < 4; c++) begin
            stall_i = (c < 3);
            @(negedge clk);
            total++; if (flag_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00500513 || mem_req_o !== 1'b0) begin
                bad++; $display("FAIL stall_hold c=%0d flag=%b pc=%h inst=%h req=%b expected 1 0 00500513 0", c, flag_o, pc_o, inst_o, mem_req_o);
            end
            tick();
        end
    endtask

    task automatic test_grant_gap();
        logic [31:0] ea;
        for (int c = 0; c <= 7; c++) begin
            mem_grant_i = !(c == 1 || c == 2);
            @(negedge clk);
            ea = (c == 0) ? 32'd4 : (c <= 3) ? 32'd5 : (c <= 5) ? 32'(c + 2) : 32'd0;
            total++; if (mem_req_o !== (c <= 5) || mem_addr_o !== ea) begin
                bad++; $display("FAIL gap_addr c=%0d req=%b addr=%h expected %b %h", c, mem_req_o, mem_addr_o, c <= 5, ea);
            end
            total++; if (flag_o !== (c == 7)) begin
                bad++; $display("FAIL gap_flag c=%0d flag=%b expected %b", c, flag_o, c == 7);
            end
            if (c == 7) begin
                total++; if (pc_o !== 32'd4 || inst_o !== word_at(32'd4)) begin
                    bad++; $display("FAIL gap_word pc=%h inst=%h expected 4 %h", pc_o, inst_o, word_at(32'd4));
                end
            end
            tick();
        end
        mem_grant_i = 1;
    endtask

    task automatic test_jump();
        logic [31:0] ea;
        for (int c = 0; c <= 8; c++) begin
            jump_i = (c == 2);
            jump_addr_i = 32'h100;
            @(negedge clk);
            ea = (c <= 2) ? 32'(c + 8) : (c <= 6) ? 32'(32'h100 + c - 3) : 32'h0;
            total++; if (mem_req_o !== (c <= 6) || mem_addr_o !== ea) begin
                bad++; $display("FAIL jump_addr c=%0d req=%b addr=%h expected %b %h", c, mem_req_o, mem_addr_o, c <= 6, ea);
            end
            total++; if (flag_o !== (c == 8)) begin
                bad++; $display("FAIL jump_flag c=%0d flag=%b expected %b", c, flag_o, c == 8);
            end
            if (c == 8) begin
                total++; if (pc_o !== 32'h100 || inst_o !== word_at(32'h100)) begin
                    bad++; $display("FAIL jump_word pc=%h inst=%h expected 100 %h", pc_o, inst_o, word_at(32'h100));
                end
            end
            tick();
        end
        jump_i = 0;
    endtask

    task automatic test_rdy();
        int seen;
        seen = -1;
        for (int c = 0; c < 30 && seen < 0; c++) begin
            rdy = !(c >= 2 && c < 6);
            @(negedge clk);
            if (!rdy) begin
                total++; if (mem_req_o !== 1'b0) begin
                    bad++; $display("FAIL rdy_req c=%0d req=%b expected 0", c, mem_req_o);
                end
            end else if (mem_req_o) begin
                total++; if (mem_addr_o !== exp_pc + 32'(exp_k)) begin
                    bad++; $display("FAIL rdy_addr c=%0d addr=%h expected %h", c, mem_addr_o, exp_pc + 32'(exp_k));
                end
            end
            if (flag_o === 1'b1) begin
                seen = c;
                total++; if (pc_o !== 32'h104 || inst_o !== word_at(32'h104)) begin
                    bad++; $display("FAIL rdy_word pc=%h inst=%h expected 104 %h", pc_o, inst_o, word_at(32'h104));
                end
            end
            tick();
        end
        rdy = 1;
        total++; if (seen != 9) begin
            bad++; $display("FAIL rdy_latency flag cycle=%0d expected 9", seen);
        end
    endtask

    task automatic test_cache();
`ifdef ICACHE_EN
        for (int c = 0; c <= 2; c++) begin
            jump_i = (c == 0);
            jump_addr_i = 32'h0;
            @(negedge clk);
            if (c == 1) begin
                total++; if (mem_req_o !== 1'b0 || flag_o !== 1'b0) begin
                    bad++; $display("FAIL cache_idle req=%b flag=%b expected 0 0", mem_req_o, flag_o);
                end
            end
            if (c == 2) begin
                total++; if (flag_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00500513 || mem_req_o !== 1'b0) begin
                    bad++; $display("FAIL cache_hit flag=%b pc=%h inst=%h req=%b expected 1 0 00500513 0", flag_o, pc_o, inst_o, mem_req_o);
                end
            end
            tick();
        end
        jump_i = 0;
`endif
    endtask

    task automatic test_random();
        int flags;
        flags = 0;
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            mem_grant_i = ($urandom_range(0, 9) < 7);
            stall_i = ($urandom_range(0, 9) < 3);
            jump_i = ($urandom_range(0, 39) == 0);
            jump_addr_i = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(0, 511));
            @(negedge clk);
            if (!rdy) begin
                total++; if (mem_req_o !== 1'b0) begin
                    bad++; $display("FAIL rnd_rdy c=%0d req=%b expected 0", c, mem_req_o);
                end
            end
            if (mem_req_o === 1'b1) begin
                total++; if (mem_addr_o !== exp_pc + 32'(exp_k) || exp_k >= 4) begin
                    bad++; $display("FAIL rnd_addr c=%0d addr=%h k=%0d expected %h with k<4", c, mem_addr_o, exp_k, exp_pc + 32'(exp_k));
                end
            end
            if (jumped) begin
                total++; if (flag_o !== 1'b0) begin
                    bad++; $display("FAIL rnd_wrongpath c=%0d flag=%b expected 0", c, flag_o);
                end
            end
            if (flag_o === 1'b1 && !prev_flag) begin
                flags++;
                total++; if (pc_o !== exp_pc || inst_o !== word_at(exp_pc)) begin
                    bad++; $display("FAIL rnd_word c=%0d pc=%h inst=%h expected %h %h", c, pc_o, inst_o, exp_pc, word_at(exp_pc));
                end
            end else if (flag_o === 1'b1) begin
                total++; if (pc_o !== prev_pc || inst_o !== prev_inst) begin
                    bad++; $display("FAIL rnd_stable c=%0d pc=%h inst=%h expected %h %h", c, pc_o, inst_o, prev_pc, prev_inst);
                end
            end
            tick();
        end
        total++; if (flags < 50) begin
            bad++; $display("FAIL rnd_progress instructions=%0d expected at least 50", flags);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
        test_reset();
        test_stall();
        test_grant_gap();
        test_jump();
        test_rdy();
        test_cache();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
